histogram_mc: RTL
=================

// Module: histogram_mc
// PURPOSE
//  Multi-channel successor of the single-channel histogram for the pulse-oximetry datapath.
//  Bins quantised samples from NCH channels (e.g. RED/IR) into per-channel histograms.
//  Each channel has its own sample window, saturating bin counts and a running peak-bin tracker.
//  Sits after the quantiser; the read port is polled by the SpO2 controller once full_out is set.
// PARAMETERS
//  BIN_BITS  4  sample width; 2**BIN_BITS bins per channel
//  CNT_BITS  8  width of each bin count, sample counter and window size
//  NCH       2  number of channels (>=1)
//  CH_BITS   1  channel select width, = max(1,clog2(NCH))
// PORTS
//  clk           in   1                    single clock, rising edge
//  rst           in   1                    async active-high reset
//  clear_in      in   1                    restart clear sweep of all channels
//  we_in         in   1                    sample valid
//  ch_in         in   CH_BITS              channel of sample
//  wdata_in      in   BIN_BITS             sample value = bin index
//  win_size_in   in   CNT_BITS             samples per window per channel; 0 = unlimited
//  raddr_in      in   CH_BITS+BIN_BITS     {channel,bin} read address
//  rdata_out     out  CNT_BITS             bin count at raddr_in
//  peak_bin_out  out  BIN_BITS             peak bin of channel raddr_in[MSBs]
//  peak_cnt_out  out  CNT_BITS             count of that peak bin
//  ready_out     out  1                    1 = accumulating (clear sweep done)
//  full_out      out  NCH                  per-channel window complete
//  drop_out      out  1                    1-cycle pulse: write rejected
// BEHAVIOUR
//  Reset: all outputs 0, FSM=CLEAR, sweep pointer=0. Storage is not reset by rst; the sweep zeroes it.
//  FSM CLEAR: zeroes one entry per cycle, NCH*2**BIN_BITS cycles total.
//   - Also zeroes sample counters, peaks and full_out.
//   - ready_out=0; we_in in CLEAR -> drop_out=1.
//   - After the last entry -> ACC; ready_out=1 from the next cycle on.
//  FSM ACC: accepts a write when we_in=1, ch_in<NCH and full_out[ch_in]=0.
//   - Bin {ch_in,wdata_in} += 1, saturating at 2**CNT_BITS-1.
//   - Sample counter of ch_in += 1.
//   - Otherwise (we_in=1 only) drop_out=1 next cycle.
//  Storage is a flop array; read-modify-write completes in one cycle.
//   - Back-to-back writes to the same bin are each counted; no hazard.
//  Window: when accepted count of ch reaches win_size_in (!=0), full_out[ch]=1 from the next cycle.
//   - full_out[ch] stays set until CLEAR.
//   - win_size_in is sampled continuously; lowering it below the current count sets full next cycle.
//  Peak (per channel): on an accepted write, if the new bin count > peak_cnt, take that bin and count.
//   - Ties keep the older peak.
//   - Initial peak = bin 0, count 0.
//  Read: rdata_out, peak_bin_out and peak_cnt_out are registered with 1-cycle latency.
//   - Read-before-write: a same-cycle write to raddr_in is visible one cycle later.
//   - During CLEAR, reads return the current memory contents (partially cleared).
//  clear_in=1 in any state: CLEAR restarts at pointer 0 next cycle; a same-cycle write is dropped.
//  rst mid-operation: immediate return to reset state; the sweep re-runs.
//  Widths: sample counters are CNT_BITS wide and do not wrap (capped by the window or saturation).
// TESTING
//  T1 reset: rst 3 cycles -> ready_out=0 for 32 cycles (NCH=2, BIN_BITS=4), then 1.
//   - All 32 reads return 0.
//  T2 accumulate: win=5; ch0 writes 5,7,7,2,0.
//   - Reads {0,7}=2, {0,5}=1, {0,3}=0.
//   - full_out=2'b01 one cycle after the 5th write; a 6th ch0 write -> drop_out pulse, counts unchanged.
//  T3 interleave: win=0; alternate ch0=3 and ch1=3, 4 each.
//   - Both bins read 4; full_out=0.
//   - peak_bin_out=3 and peak_cnt_out=4 for both channels.
//  T4 saturation: win=0; 300 writes ch1=9 -> bin {1,9}=255, peak_cnt=255.
//  T5 tie/peak: ch0 writes 4,6,6,4 -> peak_bin=6, count 2 (tie keeps 6).
//  T6 clear mid-run: assert clear_in during writes -> that write dropped, ready_out=0 for 32 cycles.
//   - Afterwards all bins, peaks and full_out read 0.

Source files
------------

// File: rtl/histogram_mc.sv
// Per-channel histograms with saturating bins, sample windows and peak tracking.
// A clear sweep zeroes the bin store one entry per cycle before accumulation starts.
module histogram_mc #(
  parameter int BIN_BITS = 4,
  parameter int CNT_BITS = 8,
  parameter int NCH      = 2,
  parameter int CH_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear_in,
  input  logic                        we_in,
  input  logic [CH_BITS-1:0]          ch_in,
  input  logic [BIN_BITS-1:0]         wdata_in,
  input  logic [CNT_BITS-1:0]         win_size_in,
  input  logic [CH_BITS+BIN_BITS-1:0] raddr_in,
  output logic [CNT_BITS-1:0]         rdata_out,
  output logic [BIN_BITS-1:0]         peak_bin_out,
  output logic [CNT_BITS-1:0]         peak_cnt_out,
  output logic                        ready_out,
  output logic [NCH-1:0]              full_out,
  output logic                        drop_out
);
  localparam int AW    = CH_BITS + BIN_BITS;
  localparam int DEPTH = NCH * (2 ** BIN_BITS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {S_CLEAR = 1'b0, S_ACC = 1'b1} state_t;

  state_t                       state_q, state_d;
  logic [AW-1:0]                ptr_q, ptr_d;
  logic [CNT_BITS-1:0]          mem_q [DEPTH];

  logic                         sweep_en, zero_ch, accept, ch_ok;
  logic [AW-1:0]                waddr;
  logic [CNT_BITS-1:0]          bin_old, bin_inc;
  logic [CH_BITS-1:0]           rch;
  logic [NCH-1:0]               full_vec;
  logic [NCH-1:0][BIN_BITS-1:0] pbin_vec;
  logic [NCH-1:0][CNT_BITS-1:0] pcnt_vec;

  logic [CNT_BITS-1:0]          rdata_q, ocnt_q;
  logic [BIN_BITS-1:0]          obin_q;
  logic                         drop_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clear_in) begin
      state_d = S_CLEAR;
      ptr_d   = '0;
    end else if (state_q == S_CLEAR) begin
      ptr_d = ptr_q + AW'(1);
      if (ptr_q == LAST) begin
        state_d = S_ACC;
        ptr_d   = '0;
      end
    end
  end

  always_comb begin
    ready_out = 1'b0;
    sweep_en  = 1'b0;
    zero_ch   = clear_in;
    if (state_q == S_ACC) begin
      ready_out = 1'b1;
    end else begin
      zero_ch  = 1'b1;
      sweep_en = !clear_in;
    end
  end

  assign waddr   = {ch_in, wdata_in};
  assign ch_ok   = ({1'b0, ch_in} < (CH_BITS + 1)'(NCH));
  assign accept  = ready_out && !clear_in && we_in && ch_ok && !full_vec[ch_in];
  assign bin_old = mem_q[waddr];
  assign bin_inc = (&bin_old) ? bin_old : bin_old + CNT_BITS'(1);
  assign rch     = raddr_in[AW-1 -: CH_BITS];

  // Bin store has no reset; the clear sweep is what initialises it.
  always_ff @(posedge clk) begin
    if (sweep_en) begin
      mem_q[ptr_q] <= '0;
    end else if (accept) begin
      mem_q[waddr] <= bin_inc;
    end
  end

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [CNT_BITS-1:0] cnt_q, cnt_d, pcnt_q, pcnt_d;
    logic [BIN_BITS-1:0] pbin_q, pbin_d;
    logic                full_q, full_d, hit;

    assign hit = accept && (ch_in == CH_BITS'(gi));

    always_comb begin
      cnt_d  = cnt_q;
      pcnt_d = pcnt_q;
      pbin_d = pbin_q;
      full_d = full_q;
      if (zero_ch) begin
        cnt_d  = '0;
        pcnt_d = '0;
        pbin_d = '0;
        full_d = 1'b0;
      end else begin
        if (hit) begin
          if (!(&cnt_q)) cnt_d = cnt_q + CNT_BITS'(1);
          // Strictly greater, so a tie leaves the older peak in place.
          if (bin_inc > pcnt_q) begin
            pcnt_d = bin_inc;
            pbin_d = wdata_in;
          end
        end
        if ((win_size_in != '0) && (cnt_d >= win_size_in)) full_d = 1'b1;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q  <= '0;
        pcnt_q <= '0;
        pbin_q <= '0;
        full_q <= 1'b0;
      end else begin
        cnt_q  <= cnt_d;
        pcnt_q <= pcnt_d;
        pbin_q <= pbin_d;
        full_q <= full_d;
      end
    end

    assign full_vec[gi] = full_q;
    assign pbin_vec[gi] = pbin_q;
    assign pcnt_vec[gi] = pcnt_q;
  end

  // Read data is taken before this cycle's write lands (read-before-write).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
      obin_q  <= '0;
      ocnt_q  <= '0;
      drop_q  <= 1'b0;
    end else begin
      rdata_q <= mem_q[raddr_in];
      obin_q  <= pbin_vec[rch];
      ocnt_q  <= pcnt_vec[rch];
      drop_q  <= we_in && !accept;
    end
  end

  assign rdata_out    = rdata_q;
  assign peak_bin_out = obin_q;
  assign peak_cnt_out = ocnt_q;
  assign full_out     = full_vec;
  assign drop_out     = drop_q;
endmodule
